ptc_pwr_seq: RTL and testbench
==============================

Name: ptc_pwr_seq

Overview:
Parametrised power sequencer for the PTC board's 12 V WIB supply channels. It replaces static per-channel enable bits with ordered ramp-up and reverse-order ramp-down. Each channel's power-good is checked against a timeout, and filtered alert inputs trigger an immediate all-off fault shutdown with sticky fault capture. It sits between the AXI register block (requests, mask, status) and the VP12_EN*/PG/ALERT board pins.

Parameters:
N_CH, 6, number of supply channels; channel 0 ramps first.
CNT_W, 24, width of the delay/timeout counter.
PG_TIMEOUT, 1000000, cycles allowed from enable to synchronised PG before fault.
STEP_DLY, 100000, cycles between a channel's PG and the next channel's enable; also the spacing between channels in ramp-down.
ALERT_FILT, 4, consecutive cycles an alert must be active to count; range 1..15.

Ports:
clk_axi  in  1  system clock.
rst  in  1  asynchronous active-high reset.
pwr_req  in  1  level: 1 = power up the masked channels, 0 = power down.
ch_mask  in  N_CH  1 = channel participates; sampled only on leaving IDLE.
fault_clr  in  1  single-cycle pulse; clears sticky fault state, honoured only in FAULT with pwr_req=0.
pg_in  in  N_CH  asynchronous power-good inputs, active-high.
alert_n  in  N_CH  asynchronous alert inputs, active-low.
en_out  out  N_CH  registered channel enables.
state_out  out  3  current FSM state code.
busy  out  1  1 in RAMP_UP, SETTLE, RAMP_DOWN.
fault_ch  out  N_CH  sticky: channel(s) that caused the fault.
fault_code  out  2  0 none, 1 PG timeout, 2 alert, 3 PG lost while ON.

Behaviour:
- Reset (asynchronous) clears everything: en_out=0, state=IDLE (0), busy=0, fault_ch=0, fault_code=0, all counters and synchronisers 0.
- pg_in and alert_n each pass through a 2-FF synchroniser.
- Alert filter: per-channel saturating counter. It increments while synchronised alert_n=0 and clears to 0 when alert_n=1. The alert is valid when count >= ALERT_FILT. Alerts are acted on only for enabled channels.
- State codes: IDLE=0, RAMP_UP=1, SETTLE=2, ON=3, RAMP_DOWN=4, FAULT=5.
- IDLE: when pwr_req=1, latch ch_mask into an internal active mask and go to RAMP_UP at the lowest active channel.
  - If the mask is 0, go straight to ON.
- RAMP_UP: set en_out[i] and clear the counter on entry.
  - Synchronised PG[i]=1 → SETTLE.
  - Counter reaches PG_TIMEOUT-1 without PG → FAULT, code 1.
- SETTLE: count STEP_DLY cycles, then move to the next higher active channel in RAMP_UP. If no active channel remains → ON.
- ON: all active channels enabled. Loss of synchronised PG on any enabled channel → FAULT, code 3.
- pwr_req=0 while in RAMP_UP, SETTLE or ON → RAMP_DOWN.
  - Starting from the highest currently enabled channel, clear one en_out bit.
  - Wait STEP_DLY cycles, then clear the next lower enabled bit.
  - After the last bit is cleared → IDLE.
  - pwr_req returning to 1 during RAMP_DOWN is ignored until IDLE is reached.
- Alert in RAMP_UP, SETTLE, ON or RAMP_DOWN → FAULT, code 2.
- FAULT:
  - en_out=0 on the same clock edge that enters FAULT; no ramp-down ordering.
  - fault_ch is the OR of the offending channels from that cycle.
  - Priority when several faults coincide: alert (2) > PG lost (3) > timeout (1).
  - FAULT is left only on fault_clr=1 with pwr_req=0: fault_ch and fault_code clear and state → IDLE on the next cycle. A fault_clr with pwr_req=1 is ignored.
- Latency: the ramp-up decision follows a PG edge on pg_in by 2 sync cycles plus 1 FSM cycle. Fault shutdown follows the alert pin by 2 + ALERT_FILT + 1 cycles.
- Counter is CNT_W bits. PG_TIMEOUT and STEP_DLY must each be < 2^CNT_W (checked by an elaboration assertion). STEP_DLY=0 means the next step follows immediately, after one cycle.

Decomposition:
- Package ptc_pkg holds the state enumeration and the fault_code constants (FLT_NONE, FLT_PG_TO, FLT_ALERT, FLT_PG_LOST).
- One sub-module, ptc_sync_filt, is instantiated per channel. It contains the 2-FF synchroniser plus the alert filter and outputs pg_s and alert_v.

Test Plan (N_CH=4, PG_TIMEOUT=50, STEP_DLY=10, ALERT_FILT=4):
1. Nominal ramp: mask=4'b1011, pwr_req=1, each PG driven 5 cycles after its enable. Expect enables in order ch0, ch1, ch3; ch2 never enabled; each enable 10 cycles after the prior PG plus sync latency; state ON, busy=0.
2. Ramp-down: from ON, pwr_req=0. Expect en_out 1011→0011→0001→0000 at 10-cycle spacing, then IDLE.
3. PG timeout: ch1 PG held 0. Expect FAULT 50 cycles after en_out[1] rose, en_out=0, fault_ch=4'b0010, fault_code=1.
4. Alert glitch vs real: alert_n[0] low for 3 cycles → no fault. Low for 4 cycles → FAULT, fault_code=2, fault_ch=4'b0001, en_out=0 at cycle 2+4+1.
5. Fault clear rules: fault_clr while pwr_req=1 → remain in FAULT. fault_clr with pwr_req=0 → IDLE, fault_ch=0, fault_code=0.
6. Async reset mid-RAMP_UP with ch0 enabled: en_out=0 and state IDLE immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ptc_pkg.sv
// Shared types and constants for the PTC 12 V WIB power sequencer.
package ptc_pkg;

  localparam int unsigned STATE_W     = 3;
  localparam int unsigned FLT_W       = 2;
  localparam int unsigned ALERT_CNT_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_RAMP_UP   = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_ON        = 3'd3,
    ST_RAMP_DOWN = 3'd4,
    ST_FAULT     = 3'd5
  } state_t;

  localparam logic [FLT_W-1:0] FLT_NONE    = 2'd0;
  localparam logic [FLT_W-1:0] FLT_PG_TO   = 2'd1;
  localparam logic [FLT_W-1:0] FLT_ALERT   = 2'd2;
  localparam logic [FLT_W-1:0] FLT_PG_LOST = 2'd3;

endpackage

// File: rtl/ptc_sync_filt.sv
// Per-channel 2-FF synchronisers for PG and ALERT_N, plus a saturating
// alert glitch filter.
module ptc_sync_filt
  import ptc_pkg::*;
#(
  parameter int unsigned ALERT_FILT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pg_in,
  input  logic alert_n,
  output logic pg_s,
  output logic alert_v
);

  localparam logic [ALERT_CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [ALERT_CNT_W-1:0] CNT_TRIP = ALERT_CNT_W'(ALERT_FILT - 1);

  logic                   pg_m;
  logic                   al_m;
  logic                   al_s;
  logic [ALERT_CNT_W-1:0] cnt;

  // alert_v is registered alongside the count so it rises the cycle cnt hits ALERT_FILT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pg_m    <= 1'b0;
      pg_s    <= 1'b0;
      al_m    <= 1'b0;
      al_s    <= 1'b0;
      cnt     <= '0;
      alert_v <= 1'b0;
    end else begin
      pg_m <= pg_in;
      pg_s <= pg_m;
      al_m <= alert_n;
      al_s <= al_m;
      if (!al_s) begin
        if (cnt != CNT_MAX) cnt <= cnt + ALERT_CNT_W'(1);
        alert_v <= (cnt >= CNT_TRIP);
      end else begin
        cnt     <= '0;
        alert_v <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ptc_pwr_seq.sv
// Ordered ramp-up / reverse ramp-down sequencer for the WIB 12 V channels,
// with PG timeout, PG-loss and filtered-alert fault shutdown.
module ptc_pwr_seq
  import ptc_pkg::*;
#(
  parameter int unsigned N_CH       = 6,
  parameter int unsigned CNT_W      = 24,
  parameter int unsigned PG_TIMEOUT = 1000000,
  parameter int unsigned STEP_DLY   = 100000,
  parameter int unsigned ALERT_FILT = 4
) (
  input  logic                clk_axi,
  input  logic                rst,
  input  logic                pwr_req,
  input  logic [N_CH-1:0]     ch_mask,
  input  logic                fault_clr,
  input  logic [N_CH-1:0]     pg_in,
  input  logic [N_CH-1:0]     alert_n,
  output logic [N_CH-1:0]     en_out,
  output logic [STATE_W-1:0]  state_out,
  output logic                busy,
  output logic [N_CH-1:0]     fault_ch,
  output logic [FLT_W-1:0]    fault_code
);

  if (PG_TIMEOUT == 0 || (64'(PG_TIMEOUT) >> CNT_W) != 64'd0) begin : g_bad_timeout
    $error("PG_TIMEOUT must be in 1..2**CNT_W-1");
  end
  if ((64'(STEP_DLY) >> CNT_W) != 64'd0) begin : g_bad_step
    $error("STEP_DLY must be below 2**CNT_W");
  end
  if (ALERT_FILT < 1 || ALERT_FILT > 15) begin : g_bad_filt
    $error("ALERT_FILT must be in 1..15");
  end

  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(PG_TIMEOUT - 1);
  localparam logic [CNT_W:0]   STEP_LIM = (CNT_W+1)'(STEP_DLY);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [N_CH-1:0]   cur;
  logic [N_CH-1:0]   pend;
  logic [N_CH-1:0]   pg_s;
  logic [N_CH-1:0]   alert_v;

  logic [N_CH-1:0]   alert_hit;
  logic [N_CH-1:0]   pg_lost;
  logic              pg_cur;
  logic              step_done;
  logic [N_CH-1:0]   mask_low;
  logic [N_CH-1:0]   pend_low;
  logic [N_CH-1:0]   dn_rest;
  logic [FLT_W-1:0]  flt_code;
  logic [N_CH-1:0]   flt_ch;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    ptc_sync_filt #(.ALERT_FILT(ALERT_FILT)) u_sync (
      .clk     (clk_axi),
      .rst     (rst),
      .pg_in   (pg_in[g]),
      .alert_n (alert_n[g]),
      .pg_s    (pg_s[g]),
      .alert_v (alert_v[g])
    );
  end

  function automatic logic [N_CH-1:0] hi_bit(input logic [N_CH-1:0] v);
    logic [N_CH-1:0] r;
    r = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  // Fault detection in priority order: alert > PG lost > PG timeout
  always_comb begin
    alert_hit = alert_v & en_out;
    pg_lost   = en_out & ~pg_s;
    pg_cur    = |(pg_s & cur);
    step_done = ({1'b0, cnt} + (CNT_W+1)'(1)) >= STEP_LIM;
    mask_low  = ch_mask & (~ch_mask + N_CH'(1));
    pend_low  = pend & (~pend + N_CH'(1));
    dn_rest   = en_out & ~hi_bit(en_out);
    flt_code  = FLT_NONE;
    flt_ch    = '0;
    if (|alert_hit) begin
      flt_code = FLT_ALERT;
      flt_ch   = alert_hit;
    end else if (state == ST_ON && |pg_lost) begin
      flt_code = FLT_PG_LOST;
      flt_ch   = pg_lost;
    end else if (state == ST_RAMP_UP && !pg_cur && cnt == TO_LAST) begin
      flt_code = FLT_PG_TO;
      flt_ch   = cur;
    end
  end

  always_ff @(posedge clk_axi or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      en_out     <= '0;
      busy       <= 1'b0;
      fault_ch   <= '0;
      fault_code <= FLT_NONE;
      cnt        <= '0;
      cur        <= '0;
      pend       <= '0;
    end else if (flt_code != FLT_NONE) begin
      state      <= ST_FAULT;
      en_out     <= '0;
      busy       <= 1'b0;
      fault_ch   <= flt_ch;
      fault_code <= flt_code;
      cnt        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pwr_req) begin
            cnt <= '0;
            if (ch_mask == '0) begin
              pend  <= '0;
              state <= ST_ON;
            end else begin
              cur    <= mask_low;
              pend   <= ch_mask & ~mask_low;
              en_out <= mask_low;
              busy   <= 1'b1;
              state  <= ST_RAMP_UP;
            end
          end
        end
        ST_RAMP_UP, ST_SETTLE, ST_ON, ST_RAMP_DOWN: begin
          // One ramp-down step: drop the highest enabled channel
          if ((state != ST_RAMP_DOWN && !pwr_req) || (state == ST_RAMP_DOWN && step_done)) begin
            en_out <= dn_rest;
            cnt    <= '0;
            if (dn_rest == '0) begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              busy  <= 1'b1;
              state <= ST_RAMP_DOWN;
            end
          end else begin
            case (state)
              ST_RAMP_UP: begin
                if (pg_cur) begin
                  cnt   <= '0;
                  state <= ST_SETTLE;
                end else begin
                  cnt <= cnt + CNT_W'(1);
                end
              end
              ST_SETTLE: begin
                if (step_done) begin
                  cnt <= '0;
                  if (pend == '0) begin
                    busy  <= 1'b0;
                    state <= ST_ON;
                  end else begin
                    cur    <= pend_low;
                    pend   <= pend & ~pend_low;
                    en_out <= en_out | pend_low;
                    state  <= ST_RAMP_UP;
                  end
                end else begin
                  cnt <= cnt + CNT_W'(1);
                end
              end
              ST_RAMP_DOWN: cnt <= cnt + CNT_W'(1);
              default: ;
            endcase
          end
        end
        ST_FAULT: begin
          if (fault_clr && !pwr_req) begin
            fault_ch   <= '0;
            fault_code <= FLT_NONE;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign state_out = state;

endmodule

// File: tb/tb_ptc_pwr_seq.sv
// Directed self-checking bench for ptc_pwr_seq (4 channels, short timers).
module tb_ptc_pwr_seq;

  localparam int unsigned N_CH = 4;

  logic            clk_axi;
  logic            rst;
  logic            pwr_req;
  logic [N_CH-1:0] ch_mask;
  logic            fault_clr;
  logic [N_CH-1:0] pg_in;
  logic [N_CH-1:0] alert_n;
  logic [N_CH-1:0] en_out;
  logic [2:0]      state_out;
  logic            busy;
  logic [N_CH-1:0] fault_ch;
  logic [1:0]      fault_code;

  int errors = 0;
  int checks = 0;

  ptc_pwr_seq #(
    .N_CH(N_CH), .CNT_W(24), .PG_TIMEOUT(50), .STEP_DLY(10), .ALERT_FILT(4)
  ) dut (
    .clk_axi    (clk_axi),
    .rst        (rst),
    .pwr_req    (pwr_req),
    .ch_mask    (ch_mask),
    .fault_clr  (fault_clr),
    .pg_in      (pg_in),
    .alert_n    (alert_n),
    .en_out     (en_out),
    .state_out  (state_out),
    .busy       (busy),
    .fault_ch   (fault_ch),
    .fault_code (fault_code)
  );

  initial clk_axi = 1'b0;
  always #5 clk_axi = ~clk_axi;

  task automatic test_reset();
    rst = 1'b1; pwr_req = 1'b0; ch_mask = '0; fault_clr = 1'b0; pg_in = '0; alert_n = '1;
    repeat (2) @(negedge clk_axi);
    checks++;
    if (en_out !== 4'b0000 || state_out !== 3'd0 || busy !== 1'b0 ||
        fault_ch !== 4'b0000 || fault_code !== 2'd0) begin
      errors++;
      $display("FAIL reset_hold: en=%b st=%0d busy=%b fch=%b fcode=%0d want 0000/0/0/0000/0",
               en_out, state_out, busy, fault_ch, fault_code);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk_axi);
    checks++;
    if (en_out !== 4'b0000 || state_out !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: en=%b st=%0d busy=%b want 0000/0/0", en_out, state_out, busy);
    end
  endtask

  task automatic test_nominal();
    logic [N_CH-1:0] exp_en [3];
    int              chs [3];
    exp_en[0] = 4'b0001; exp_en[1] = 4'b0011; exp_en[2] = 4'b1011;
    chs[0] = 0; chs[1] = 1; chs[2] = 3;
    ch_mask = 4'b1011; pwr_req = 1'b1;
    @(negedge clk_axi);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (en_out !== exp_en[k] || state_out !== 3'd1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL nom_enable%0d: en=%b st=%0d busy=%b want %b/1/1", k, en_out, state_out, busy, exp_en[k]);
      end
      repeat (5) @(negedge clk_axi);
      pg_in[chs[k]] = 1'b1;
      repeat (3) @(negedge clk_axi);
      checks++;
      if (state_out !== 3'd2 || busy !== 1'b1) begin
        errors++;
        $display("FAIL nom_settle%0d: st=%0d busy=%b want 2/1", k, state_out, busy);
      end
      repeat (9) @(negedge clk_axi);
      checks++;
      if (en_out !== exp_en[k] || state_out !== 3'd2) begin
        errors++;
        $display("FAIL nom_hold%0d: en=%b st=%0d want %b/2", k, en_out, state_out, exp_en[k]);
      end
      @(negedge clk_axi);
    end
    checks++;
    if (state_out !== 3'd3 || busy !== 1'b0 || en_out !== 4'b1011) begin
      errors++;
      $display("FAIL nom_on: st=%0d busy=%b en=%b want 3/0/1011", state_out, busy, en_out);
    end
  endtask

  task automatic test_ramp_down();
    pwr_req = 1'b0;
    @(negedge clk_axi);
    checks++;
    if (en_out !== 4'b0011 || state_out !== 3'd4 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rd_first: en=%b st=%0d busy=%b want 0011/4/1", en_out, state_out, busy);
    end
    pwr_req = 1'b1;
    repeat (9) @(negedge clk_axi);
    checks++;
    if (en_out !== 4'b0011 || state_out !== 3'd4) begin
      errors++;
      $display("FAIL rd_hold1: en=%b st=%0d want 0011/4", en_out, state_out);
    end
    @(negedge clk_axi);
    checks++;
    if (en_out !== 4'b0001 || state_out !== 3'd4) begin
      errors++;
      $display("FAIL rd_second: en=%b st=%0d want 0001/4", en_out, state_out);
    end
    repeat (9) @(negedge clk_axi);
    checks++;
    if (en_out !== 4'b0001 || state_out !== 3'd4) begin
      errors++;
      $display("FAIL rd_hold2: en=%b st=%0d want 0001/4", en_out, state_out);
    end
    @(negedge clk_axi);
    pwr_req = 1'b0;
    checks++;
    if (en_out !== 4'b0000 || state_out !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rd_idle: en=%b st=%0d busy=%b want 0000/0/0", en_out, state_out, busy);
    end
    pg_in = '0;
    repeat (3) @(negedge clk_axi);
  endtask

  task automatic test_pg_timeout();
    ch_mask = 4'b0011; pg_in = 4'b0001; pwr_req = 1'b1;
    for (int i = 0; i < 100 && en_out[1] !== 1'b1; i++) @(negedge clk_axi);
    checks++;
    if (en_out[1] !== 1'b1) begin
      errors++;
      $display("FAIL to_wait_en1: en=%b want en[1]=1 within 100 cycles", en_out);
    end
    repeat (49) @(negedge clk_axi);
    checks++;
    if (state_out !== 3'd1 || en_out !== 4'b0011) begin
      errors++;
      $display("FAIL to_before: st=%0d en=%b want 1/0011", state_out, en_out);
    end
    @(negedge clk_axi);
    checks++;
    if (state_out !== 3'd5 || en_out !== 4'b0000 || fault_ch !== 4'b0010 ||
        fault_code !== 2'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL to_fault: st=%0d en=%b fch=%b fcode=%0d busy=%b want 5/0000/0010/1/0",
               state_out, en_out, fault_ch, fault_code, busy);
    end
  endtask

  task automatic test_fault_clr();
    fault_clr = 1'b1;
    @(negedge clk_axi);
    fault_clr = 1'b0;
    checks++;
    if (state_out !== 3'd5 || fault_code !== 2'd1 || fault_ch !== 4'b0010) begin
      errors++;
      $display("FAIL clr_ignored: st=%0d fcode=%0d fch=%b want 5/1/0010", state_out, fault_code, fault_ch);
    end
    pwr_req = 1'b0; fault_clr = 1'b1;
    @(negedge clk_axi);
    fault_clr = 1'b0;
    checks++;
    if (state_out !== 3'd0 || fault_code !== 2'd0 || fault_ch !== 4'b0000 || en_out !== 4'b0000) begin
      errors++;
      $display("FAIL clr_taken: st=%0d fcode=%0d fch=%b en=%b want 0/0/0000/0000",
               state_out, fault_code, fault_ch, en_out);
    end
    pg_in = '0;
    repeat (3) @(negedge clk_axi);
  endtask

  task automatic test_alert();
    ch_mask = 4'b0001; pg_in = 4'b0001; pwr_req = 1'b1;
    for (int i = 0; i < 50 && state_out !== 3'd3; i++) @(negedge clk_axi);
    checks++;
    if (state_out !== 3'd3 || en_out !== 4'b0001) begin
      errors++;
      $display("FAIL al_reach_on: st=%0d en=%b want 3/0001", state_out, en_out);
    end
    alert_n[0] = 1'b0;
    repeat (3) @(negedge clk_axi);
    alert_n[0] = 1'b1;
    repeat (10) @(negedge clk_axi);
    checks++;
    if (state_out !== 3'd3 || fault_code !== 2'd0 || en_out !== 4'b0001) begin
      errors++;
      $display("FAIL al_glitch: st=%0d fcode=%0d en=%b want 3/0/0001", state_out, fault_code, en_out);
    end
    alert_n[0] = 1'b0;
    repeat (4) @(negedge clk_axi);
    alert_n[0] = 1'b1;
    repeat (2) @(negedge clk_axi);
    checks++;
    if (state_out !== 3'd3 || en_out !== 4'b0001) begin
      errors++;
      $display("FAIL al_before: st=%0d en=%b want 3/0001", state_out, en_out);
    end
    @(negedge clk_axi);
    checks++;
    if (state_out !== 3'd5 || fault_code !== 2'd2 || fault_ch !== 4'b0001 || en_out !== 4'b0000) begin
      errors++;
      $display("FAIL al_fault: st=%0d fcode=%0d fch=%b en=%b want 5/2/0001/0000",
               state_out, fault_code, fault_ch, en_out);
    end
    pwr_req = 1'b0; fault_clr = 1'b1;
    @(negedge clk_axi);
    fault_clr = 1'b0; pg_in = '0;
    checks++;
    if (state_out !== 3'd0 || fault_code !== 2'd0) begin
      errors++;
      $display("FAIL al_clear: st=%0d fcode=%0d want 0/0", state_out, fault_code);
    end
    repeat (3) @(negedge clk_axi);
  endtask

  task automatic test_empty_mask();
    ch_mask = 4'b0000; pwr_req = 1'b1;
    @(negedge clk_axi);
    checks++;
    if (state_out !== 3'd3 || en_out !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL empty_on: st=%0d en=%b busy=%b want 3/0000/0", state_out, en_out, busy);
    end
    pwr_req = 1'b0;
    @(negedge clk_axi);
    checks++;
    if (state_out !== 3'd0) begin
      errors++;
      $display("FAIL empty_idle: st=%0d want 0", state_out);
    end
  endtask

  task automatic test_async_reset();
    ch_mask = 4'b0001; pg_in = '0; pwr_req = 1'b1;
    @(negedge clk_axi);
    checks++;
    if (en_out !== 4'b0001 || state_out !== 3'd1) begin
      errors++;
      $display("FAIL ar_ramp: en=%b st=%0d want 0001/1", en_out, state_out);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (en_out !== 4'b0000 || state_out !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ar_immediate: en=%b st=%0d busy=%b want 0000/0/0", en_out, state_out, busy);
    end
    @(negedge clk_axi);
    rst = 1'b0; pwr_req = 1'b0;
    @(negedge clk_axi);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_ramp_down();
    test_pg_timeout();
    test_fault_clr();
    test_alert();
    test_empty_mask();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
